// File: rtl/pipeline_top.sv
// pipeline_top: 3-stage (IF/EX/WB) CPU with 16-bit instructions, an 8x32 register
// file and a mode-0 SPI master. ROM_SEL picks the program image (0 = SPI demo, 1 = bypass demo).
module pipeline_top #(
  parameter int ROM_SEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  output logic        sclk,
  output logic        ss,
  output logic        mosi,
  output logic        spi_interrupt,
  output logic [31:0] ResultW
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_SPIW = 4'h7;
  localparam logic [3:0] OP_SPIR = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [15:0] rom_word(input logic [4:0] addr);
    logic [15:0] w;
    w = 16'h0000;
    if (ROM_SEL == 1) begin
      case (addr)
        5'd0:    w = 16'h6205;  // LI r1,5
        5'd1:    w = 16'h547F;  // ADDI r2,r1,-1
        default: w = 16'h0000;
      endcase
    end else begin
      case (addr)
        5'd0:    w = 16'h62A5;  // LI r1,0xA5
        5'd1:    w = 16'h7040;  // SPIW r1
        5'd2:    w = 16'h8400;  // SPIR r2
        5'd3:    w = 16'h663C;  // LI r3,0x3C
        5'd4:    w = 16'h70C0;  // SPIW r3
        5'd5:    w = 16'h8800;  // SPIR r4
        5'd6:    w = 16'h1AA0;  // ADD r5,r2,r4
        5'd7:    w = 16'hF000;  // HALT
        default: w = 16'h0000;
      endcase
    end
    return w;
  endfunction

  logic [4:0]  pc_q, pc_d;
  logic [15:0] ex_instr_q, ex_instr_d;
  logic        halted_q, halted_d;
  logic        wb_we_q, wb_we_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [31:0] rf_q [8];

  logic        spi_busy_q, spi_busy_d;
  logic [4:0]  spi_cnt_q, spi_cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        ss_q, ss_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        irq_q, irq_d;

  logic [3:0]  op_s;
  logic [2:0]  rd_s, rs1_idx_s, rs2_idx_s;
  logic [31:0] rs1_s, rs2_s, alu_s;
  logic        writes_s, stall_s, spi_start_s;
  logic [4:0]  cnt_nxt_s;
  logic [2:0]  bit_idx_s;

  // EX decode: operand read with write-through from WB, ALU, hazard detection
  always_comb begin
    op_s      = ex_instr_q[15:12];
    rd_s      = ex_instr_q[11:9];
    rs1_idx_s = ex_instr_q[8:6];
    rs2_idx_s = ex_instr_q[5:3];
    if (rs1_idx_s == 3'd0) begin
      rs1_s = 32'd0;
    end else if (wb_we_q && (wb_rd_q == rs1_idx_s)) begin
      rs1_s = wb_val_q;
    end else begin
      rs1_s = rf_q[rs1_idx_s];
    end
    if (rs2_idx_s == 3'd0) begin
      rs2_s = 32'd0;
    end else if (wb_we_q && (wb_rd_q == rs2_idx_s)) begin
      rs2_s = wb_val_q;
    end else begin
      rs2_s = rf_q[rs2_idx_s];
    end
    writes_s = 1'b1;
    case (op_s)
      OP_ADD:  alu_s = rs1_s + rs2_s;
      OP_SUB:  alu_s = rs1_s - rs2_s;
      OP_AND:  alu_s = rs1_s & rs2_s;
      OP_OR:   alu_s = rs1_s | rs2_s;
      OP_ADDI: alu_s = rs1_s + {{26{ex_instr_q[5]}}, ex_instr_q[5:0]};
      OP_LI:   alu_s = {23'd0, ex_instr_q[8:0]};
      OP_SPIR: alu_s = {24'd0, rx_byte_q};
      default: begin
        alu_s    = 32'd0;
        writes_s = 1'b0;
      end
    endcase
    stall_s     = ((op_s == OP_SPIW) || (op_s == OP_SPIR)) && spi_busy_q;
    spi_start_s = (op_s == OP_SPIW) && !spi_busy_q;
  end

  // Pipeline control: stall, HALT freeze, JMP flush, normal advance
  always_comb begin
    pc_d       = pc_q;
    ex_instr_d = ex_instr_q;
    halted_d   = halted_q;
    wb_we_d    = 1'b0;
    wb_rd_d    = rd_s;
    wb_val_d   = 32'd0;
    if (halted_q) begin
      ex_instr_d = 16'h0000;
    end else if (stall_s) begin
      pc_d = pc_q;
    end else if (op_s == OP_HALT) begin
      halted_d   = 1'b1;
      ex_instr_d = 16'h0000;
    end else if (op_s == OP_JMP) begin
      pc_d       = ex_instr_q[4:0];
      ex_instr_d = 16'h0000;
    end else begin
      pc_d       = pc_q + 5'd1;
      ex_instr_d = rom_word(pc_q);
      // writes to r0 are dropped, so they also show as 0 on ResultW
      wb_we_d    = writes_s && (rd_s != 3'd0);
      wb_val_d   = (writes_s && (rd_s != 3'd0)) ? alu_s : 32'd0;
    end
  end

  // SPI master: 32-cycle frame of 8 bit periods (2 low + 2 high), miso sampled on sclk rise
  always_comb begin
    spi_busy_d = spi_busy_q;
    spi_cnt_d  = spi_cnt_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    irq_d      = 1'b0;
    cnt_nxt_s  = spi_cnt_q + 5'd1;
    bit_idx_s  = 3'd7 - cnt_nxt_s[4:2];
    if (spi_busy_q) begin
      if (spi_cnt_q == 5'd31) begin
        spi_busy_d = 1'b0;
        ss_d       = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        rx_byte_d  = rx_sh_q;
        irq_d      = 1'b1;
      end else begin
        spi_cnt_d = cnt_nxt_s;
        sclk_d    = cnt_nxt_s[1];
        if (cnt_nxt_s[1:0] == 2'd2) begin
          rx_sh_d = {rx_sh_q[6:0], miso};
        end else begin
          rx_sh_d = rx_sh_q;
        end
        if (cnt_nxt_s[1:0] == 2'd0) begin
          mosi_d = tx_q[bit_idx_s];
        end else begin
          mosi_d = mosi_q;
        end
      end
    end else if (spi_start_s) begin
      spi_busy_d = 1'b1;
      spi_cnt_d  = 5'd0;
      tx_d       = rs1_s[7:0];
      rx_sh_d    = 8'd0;
      ss_d       = 1'b0;
      sclk_d     = 1'b0;
      mosi_d     = rs1_s[7];
    end else begin
      spi_busy_d = 1'b0;
    end
  end

  // State registers for pipeline and SPI, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= 5'd0;
      ex_instr_q <= 16'h0000;
      halted_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_val_q   <= 32'd0;
      spi_busy_q <= 1'b0;
      spi_cnt_q  <= 5'd0;
      tx_q       <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_byte_q  <= 8'd0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ex_instr_q <= ex_instr_d;
      halted_q   <= halted_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_val_q   <= wb_val_d;
      spi_busy_q <= spi_busy_d;
      spi_cnt_q  <= spi_cnt_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      irq_q      <= irq_d;
    end
  end

  // Register file write-back
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (wb_we_q) begin
      rf_q[wb_rd_q] <= wb_val_q;
    end
  end

  assign sclk          = sclk_q;
  assign ss            = ss_q;
  assign mosi          = mosi_q;
  assign spi_interrupt = irq_q;
  assign ResultW       = wb_val_q;

endmodule

// File: tb/tb_pipeline_top.sv
// Bench for pipeline_top: SPI slave model, table of slave responses checked against a
// cycle-level expectation derived from the program, plus reset-abort and bypass sequences.
module tb_pipeline_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, ss, mosi, spi_int;
  logic [31:0] result_w;

  logic        rst_alt = 1'b0;
  logic        miso_alt = 1'b0;
  logic        sclk_a, ss_a, mosi_a, irq_a;
  logic [31:0] res_a;

  always #5 clk = ~clk;

  pipeline_top #(.ROM_SEL(0)) u_dut (
    .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .ss(ss), .mosi(mosi),
    .spi_interrupt(spi_int), .ResultW(result_w)
  );

  pipeline_top #(.ROM_SEL(1)) u_alt (
    .clk(clk), .rst(rst_alt), .miso(miso_alt), .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a),
    .spi_interrupt(irq_a), .ResultW(res_a)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // SPI slave model: one record per completed ss-low window
  logic [7:0] resp [2];
  logic [7:0] rec_rx [$];
  int         rec_low [$];
  int         rec_rises [$];
  int         irq_cnt = 0;
  logic       prev_ss = 1'b1;
  logic       prev_sclk = 1'b0;
  int         rises = 0;
  int         low_cnt = 0;
  logic [7:0] slave_rx = 8'd0;
  logic [7:0] slave_tx = 8'd0;

  always begin
    @(posedge clk);
    #1;
    if (spi_int) irq_cnt++;
    if (!ss) begin
      if (prev_ss) begin
        rises    = 0;
        low_cnt  = 0;
        slave_tx = resp[rec_rx.size() % 2];
        miso     = slave_tx[7];
        slave_tx = slave_tx << 1;
      end
      low_cnt++;
      if (sclk && !prev_sclk) begin
        rises++;
        slave_rx = {slave_rx[6:0], mosi};
      end
      if (!sclk && prev_sclk) begin
        miso     = slave_tx[7];
        slave_tx = slave_tx << 1;
      end
    end else if (!prev_ss) begin
      rec_rx.push_back(slave_rx);
      rec_low.push_back(low_cnt);
      rec_rises.push_back(rises);
      miso = 1'b0;
    end
    prev_ss   = ss;
    prev_sclk = sclk;
  end

  // Expected per-cycle outputs, index n = cycles after the first edge with rst high
  logic [31:0] exp_res [200];
  logic        exp_ss  [200];
  logic        exp_irq [200];

  task automatic build_trace(input logic [7:0] r1, input logic [7:0] r2, input logic [31:0] sum);
    int t, spiw, irq_t;
    for (int i = 0; i < 200; i++) begin
      exp_res[i] = 32'd0;
      exp_ss[i]  = 1'b1;
      exp_irq[i] = 1'b0;
    end
    t = 1;
    exp_res[t] = 32'h000000A5;
    // SPIW r1 sits in EX while LI r1 is written back; frame follows for 32 cycles
    spiw = t;
    for (int k = 1; k <= 32; k++) exp_ss[spiw + k] = 1'b0;
    irq_t = spiw + 33;
    exp_irq[irq_t] = 1'b1;
    exp_res[irq_t + 1] = {24'd0, r1};
    t = irq_t + 2;
    exp_res[t] = 32'h0000003C;
    spiw = t;
    for (int k = 1; k <= 32; k++) exp_ss[spiw + k] = 1'b0;
    irq_t = spiw + 33;
    exp_irq[irq_t] = 1'b1;
    exp_res[irq_t + 1] = {24'd0, r2};
    exp_res[irq_t + 2] = sum;
  endtask

  typedef struct {
    logic [7:0]  resp1;
    logic [7:0]  resp2;
    logic [7:0]  exp_tx1;
    logic [7:0]  exp_tx2;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs [5];

  task automatic start_program(input vec_t v);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rec_rx.delete();
    rec_low.delete();
    rec_rises.delete();
    irq_cnt = 0;
    resp[0] = v.resp1;
    resp[1] = v.resp2;
    build_trace(v.resp1, v.resp2, v.exp_sum);
    rst = 1'b1;
  endtask

  task automatic check_cycles(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("resultw@%0d", n), result_w, exp_res[n]);
      chk($sformatf("ss@%0d", n), 32'(ss), 32'(exp_ss[n]));
      chk($sformatf("irq@%0d", n), 32'(spi_int), 32'(exp_irq[n]));
    end
  endtask

  initial begin
    logic [7:0] r1, r2;
    vecs[0] = '{8'h55, 8'hAA, 8'hA5, 8'h3C, 32'h000000FF};
    vecs[1] = '{8'hFF, 8'hFF, 8'hA5, 8'h3C, 32'h000001FE};
    vecs[2] = '{8'h00, 8'h01, 8'hA5, 8'h3C, 32'h00000001};
    for (int i = 3; i < 5; i++) begin
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      vecs[i] = '{r1, r2, 8'hA5, 8'h3C, 32'(r1) + 32'(r2)};
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_irq", 32'(spi_int), 32'd0);
    chk("rst_resultw", result_w, 32'd0);

    // full program per response pair; 176 cycles covers HALT plus 100 quiet cycles
    for (int v = 0; v < 5; v++) begin
      start_program(vecs[v]);
      check_cycles(176);
      chk($sformatf("v%0d_xfers", v), 32'(rec_rx.size()), 32'd2);
      chk($sformatf("v%0d_irqs", v), 32'(irq_cnt), 32'd2);
      for (int k = 0; k < 2; k++) begin
        if (k < rec_rx.size()) begin
          chk($sformatf("v%0d_slave_rx%0d", v, k), 32'(rec_rx[k]),
              32'((k == 0) ? vecs[v].exp_tx1 : vecs[v].exp_tx2));
          chk($sformatf("v%0d_ss_low%0d", v, k), 32'(rec_low[k]), 32'd32);
          chk($sformatf("v%0d_rises%0d", v, k), 32'(rec_rises[k]), 32'd8);
        end
      end
    end

    // reset 10 cycles into the first frame aborts it silently, then the program restarts
    start_program(vecs[0]);
    repeat (13) @(posedge clk);
    #1;
    chk("abort_pre_ss", 32'(ss), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ss", 32'(ss), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_irq", 32'(spi_int), 32'd0);
    chk("abort_resultw", result_w, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_irq_cnt", 32'(irq_cnt), 32'd0);
    start_program(vecs[0]);
    check_cycles(40);

    // write-through bypass: LI r1,5 then ADDI r2,r1,-1 back to back
    @(posedge clk);
    #1;
    rst_alt = 1'b1;
    @(posedge clk);
    #1;
    chk("byp_n0", res_a, 32'd0);
    @(posedge clk);
    #1;
    chk("byp_li", res_a, 32'd5);
    @(posedge clk);
    #1;
    chk("byp_addi", res_a, 32'd4);
    chk("byp_ss", 32'(ss_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
